mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Registered, handshaked successor of the combinational MEM stage: sits between EX/MEM pipeline register and MEM/WB.
//  Drives memctl with a held request until memctl_fin, corrects load extension (full byte/half), checks alignment,
//  and accepts a new instruction in the completion cycle for back-to-back memory ops. XLEN and forwarding timing are parametrised.
// PARAMETERS
//  XLEN       32  datapath / memctl data and address width
//  REG_AW     5   register-file address width
//  CHECK_ALIGN 1  1: misaligned LH/LHU/LW/SH/SW raise exc_misaligned, no memctl access; 0: issued unchecked
//  EARLY_FWD  1   1: load value forwarded combinationally in the memctl_fin cycle; 0: forwarded from output regs only
// PORTS
//  clk_in          in   1       clock, all state on posedge
//  rst_in          in   1       synchronous reset, active-low
//  rdy_in          in   1       global enable; low freezes all state and outputs
//  in_valid        in   1       EX/MEM slot holds an instruction
//  forward         in   1       instruction writes rd (non-memory ops)
//  rd_addr         in   REG_AW  destination register
//  rd_val          in   XLEN    ALU result (non-memory ops)
//  ins_type        in   7       opcode; LOAD / SAVE from package, all else pass-through
//  ins_details     in   3       funct3: LB LH LW LBU LHU / SB SH SW
//  mem_addr        in   XLEN    effective address
//  mem_val         in   XLEN    store data, LSB-justified
//  memctl_op       out  2       MEM_NOP / MEM_LOAD / MEM_SAVE
//  memctl_len      out  2       MEM_BYTE / MEM_HALF / MEM_WORD
//  memctl_addr     out  XLEN    request address
//  memctl_data     out  XLEN    store data
//  memctl_fin      in   1       request complete this cycle
//  memctl_out      in   XLEN    load data, LSB-justified, valid with memctl_fin
//  stall           out  3       STALL_MEM while upstream must hold, else 3'b000
//  out_valid       out  1       output regs hold a retired instruction (one cycle per instruction)
//  output_rd_addr  out  REG_AW  writeback register (0 when no write)
//  output_rd_val   out  XLEN    writeback value
//  output_ins_type out  7       opcode of retired instruction
//  exc_misaligned  out  1       retired instruction was misaligned (valid with out_valid)
//  output_forward  out  1       forward bus valid
//  forward_rd_addr out  REG_AW  forward register
//  forward_rd_val  out  XLEN    forward value
// BEHAVIOUR
//  - Reset (rst_in==0 at posedge): state IDLE; memctl_op=NOP, len/addr/data=0; out_valid, exc_misaligned,
//    output_forward=0; all addr/val outputs 0; output_ins_type=ADDI. Mid-transaction reset abandons the request.
//  - rdy_in==0: no state, register or output change; stall still computed from held state.
//  - States: IDLE, BUSY. accept = in_valid & rdy_in & (IDLE | (BUSY & memctl_fin)).
//  - accept of non-memory op: next cycle out_valid=1, output_* = inputs, rd_addr forced 0 if !forward; stay/return IDLE.
//  - accept of LOAD/SAVE, aligned: next cycle memctl_op/len/addr/data registered from latched op, state BUSY;
//    memctl outputs held constant every BUSY cycle until memctl_fin. Invalid funct3 treated as misaligned.
//  - Misaligned (CHECK_ALIGN=1, half: addr[0]!=0, word: addr[1:0]!=0): no memctl access; next cycle out_valid=1,
//    exc_misaligned=1, output_rd_addr=0, state IDLE.
//  - BUSY & memctl_fin: next cycle out_valid=1; loads: output_rd_val = extend(memctl_out) (LB sign-ext bit7,
//    LH bit15, LBU/LHU zero-ext, LW full); stores: output_rd_addr=0. memctl_op<=NOP unless another mem op accepted
//    same edge, then its request is registered directly (state stays BUSY). Minimum latency 2 cycles load/store.
//  - stall = STALL_MEM when state==BUSY & !memctl_fin, else 0. No stall in IDLE.
//  - Forwarding: output_forward/addr/val mirror output regs when out_valid & rd_addr!=0. EARLY_FWD=1: in BUSY &
//    memctl_fin of a load, forward bus carries rd_addr and extended memctl_out combinationally (priority over regs).
//  - memctl_fin outside BUSY ignored. rd_addr 0 never forwarded.
// STRUCTURE
//  - Shared header mem_defs.vh: LOAD/SAVE/ADDI opcodes, funct3 codes, MEM_NOP=2'b00 MEM_LOAD=2'b01 MEM_SAVE=2'b10,
//    MEM_BYTE=2'b00 MEM_HALF=2'b01 MEM_WORD=2'b10, STALL_MEM, ZeroWord.
//  - Sub-module mem_load_ext (combinational, XLEN param): funct3 + raw data -> extended value; also used by EARLY_FWD path.
// TESTING
//  - LB addr 0x100, memctl_out=0x80 after 3 wait cycles -> stall=STALL_MEM 3 cycles, output_rd_val=0xFFFFFF80; LBU -> 0x80.
//  - LH 0x8001 / LHU 0x8001 -> 0xFFFF8001 / 0x00008001; memctl_op/addr stable throughout BUSY.
//  - SW 0x104 data 0xDEADBEEF then LW 0x104 back-to-back, fin each after 1 cycle -> second request registered
//    on first fin edge, no IDLE gap, store retires with output_rd_addr=0.
//  - LW addr 0x102, CHECK_ALIGN=1 -> memctl_op stays NOP, next cycle exc_misaligned=1, out_valid=1, no forward.
//  - ADDI rd=5 val 7 with forward=1 -> next cycle out_valid, forward_rd_addr=5, forward_rd_val=7; rd=0 -> output_forward=0.
//  - rst_in low during BUSY -> next cycle memctl_op=NOP, state IDLE, all outputs reset; rdy_in low 2 cycles freezes outputs.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared opcodes, funct3 codes, memctl encodings and decode helpers for the
// registered memory-access stage.
package mem_access_unit_pkg;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_SAVE = 7'b0100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [1:0] MEM_NOP  = 2'b00;
  localparam logic [1:0] MEM_LOAD = 2'b01;
  localparam logic [1:0] MEM_SAVE = 2'b10;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [2:0] STALL_MEM = 3'b001;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  // Undefined funct3 encodings are reported the same way as misalignment.
  function automatic logic op_bad(input logic is_store, input logic [2:0] f3,
                                  input logic [1:0] addr_lo, input logic check);
    logic bad_f3;
    logic mis;
    if (is_store) bad_f3 = (f3 > F3_SW);
    else bad_f3 = !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
    case (f3[1:0])
      2'd1:    mis = addr_lo[0];
      2'd2:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return bad_f3 || (check && mis);
  endfunction

  function automatic logic [1:0] mem_len(input logic [2:0] f3);
    case (f3[1:0])
      2'd1:    return MEM_HALF;
      2'd2:    return MEM_WORD;
      default: return MEM_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load data extension: raw LSB-justified memctl data to the architectural
// register value, selected by the load funct3.
module mem_load_ext
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext
);

  always_comb begin
    ext = raw;
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_LH:   ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Registered, handshaked MEM stage between EX/MEM and MEM/WB: holds a memctl
// request until memctl_fin, extends loads, checks alignment, forwards results.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter bit CHECK_ALIGN = 1'b1,
  parameter bit EARLY_FWD   = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              in_valid,
  input  logic              forward,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_val,
  input  logic [6:0]        ins_type,
  input  logic [2:0]        ins_details,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_val,
  output logic [1:0]        memctl_op,
  output logic [1:0]        memctl_len,
  output logic [XLEN-1:0]   memctl_addr,
  output logic [XLEN-1:0]   memctl_data,
  input  logic              memctl_fin,
  input  logic [XLEN-1:0]   memctl_out,
  output logic [2:0]        stall,
  output logic              out_valid,
  output logic [REG_AW-1:0] output_rd_addr,
  output logic [XLEN-1:0]   output_rd_val,
  output logic [6:0]        output_ins_type,
  output logic              exc_misaligned,
  output logic              output_forward,
  output logic [REG_AW-1:0] forward_rd_addr,
  output logic [XLEN-1:0]   forward_rd_val
);

  state_t            state, state_next;
  logic [REG_AW-1:0] pend_rd;
  logic [2:0]        pend_f3;
  logic              pend_load;
  logic [6:0]        pend_type;
  logic              hold_valid;
  logic [REG_AW-1:0] hold_rd;
  logic [XLEN-1:0]   hold_val;
  logic [6:0]        hold_type;
  logic              hold_exc;
  logic              is_load, is_store, bad, fin_now, accept, issue, acc_retire;
  logic [REG_AW-1:0] acc_rd;
  logic [XLEN-1:0]   acc_val;
  logic [XLEN-1:0]   ext_val;

  mem_load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3(pend_f3),
    .raw   (memctl_out),
    .ext   (ext_val)
  );

  always_comb begin
    is_load    = (ins_type == OP_LOAD);
    is_store   = (ins_type == OP_SAVE);
    bad        = (is_load || is_store) && op_bad(is_store, ins_details, mem_addr[1:0], CHECK_ALIGN);
    fin_now    = (state == ST_BUSY) && memctl_fin;
    accept     = in_valid && rdy_in && ((state == ST_IDLE) || fin_now);
    issue      = accept && (is_load || is_store) && !bad;
    acc_retire = accept && !issue;
    acc_rd     = (bad || !forward) ? '0 : rd_addr;
    acc_val    = bad ? '0 : rd_val;
    state_next = state;
    if (fin_now) state_next = ST_IDLE;
    if (issue)   state_next = ST_BUSY;
  end

  // A non-memory op accepted on a completion edge cannot share the output regs
  // with the completing load/store, so it waits one cycle in the hold slot.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state           <= ST_IDLE;
      memctl_op       <= MEM_NOP;
      memctl_len      <= MEM_BYTE;
      memctl_addr     <= '0;
      memctl_data     <= '0;
      pend_rd         <= '0;
      pend_f3         <= '0;
      pend_load       <= 1'b0;
      pend_type       <= OP_ADDI;
      hold_valid      <= 1'b0;
      hold_rd         <= '0;
      hold_val        <= '0;
      hold_type       <= OP_ADDI;
      hold_exc        <= 1'b0;
      out_valid       <= 1'b0;
      output_rd_addr  <= '0;
      output_rd_val   <= '0;
      output_ins_type <= OP_ADDI;
      exc_misaligned  <= 1'b0;
    end else if (rdy_in) begin
      state <= state_next;
      if (issue) begin
        memctl_op   <= is_store ? MEM_SAVE : MEM_LOAD;
        memctl_len  <= mem_len(ins_details);
        memctl_addr <= mem_addr;
        memctl_data <= mem_val;
        pend_rd     <= rd_addr;
        pend_f3     <= ins_details;
        pend_load   <= is_load;
        pend_type   <= ins_type;
      end else if (fin_now) begin
        memctl_op   <= MEM_NOP;
        memctl_len  <= MEM_BYTE;
        memctl_addr <= '0;
        memctl_data <= '0;
      end
      out_valid <= fin_now || hold_valid || acc_retire;
      if (fin_now) begin
        output_rd_addr  <= pend_load ? pend_rd : '0;
        output_rd_val   <= pend_load ? ext_val : '0;
        output_ins_type <= pend_type;
        exc_misaligned  <= 1'b0;
      end else if (hold_valid) begin
        output_rd_addr  <= hold_rd;
        output_rd_val   <= hold_val;
        output_ins_type <= hold_type;
        exc_misaligned  <= hold_exc;
      end else if (acc_retire) begin
        output_rd_addr  <= acc_rd;
        output_rd_val   <= acc_val;
        output_ins_type <= ins_type;
        exc_misaligned  <= bad;
      end else begin
        exc_misaligned  <= 1'b0;
      end
      if ((fin_now || hold_valid) && acc_retire) begin
        hold_valid <= 1'b1;
        hold_rd    <= acc_rd;
        hold_val   <= acc_val;
        hold_type  <= ins_type;
        hold_exc   <= bad;
      end else begin
        hold_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    output_forward  = 1'b0;
    forward_rd_addr = '0;
    forward_rd_val  = '0;
    if (EARLY_FWD && rdy_in && fin_now && pend_load && (pend_rd != '0)) begin
      output_forward  = 1'b1;
      forward_rd_addr = pend_rd;
      forward_rd_val  = ext_val;
    end else if (out_valid && (output_rd_addr != '0)) begin
      output_forward  = 1'b1;
      forward_rd_addr = output_rd_addr;
      forward_rd_val  = output_rd_val;
    end
  end

  assign stall = ((state == ST_BUSY) && !memctl_fin) ? STALL_MEM : 3'b000;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads with extension, store/load
// back-to-back, misalignment, forwarding, reset and rdy_in freeze.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, in_valid, forward;
  logic [4:0]  rd_addr;
  logic [31:0] rd_val;
  logic [6:0]  ins_type;
  logic [2:0]  ins_details;
  logic [31:0] mem_addr, mem_val;
  logic [1:0]  memctl_op, memctl_len;
  logic [31:0] memctl_addr, memctl_data;
  logic        memctl_fin;
  logic [31:0] memctl_out;
  logic [2:0]  stall;
  logic        out_valid;
  logic [4:0]  output_rd_addr;
  logic [31:0] output_rd_val;
  logic [6:0]  output_ins_type;
  logic        exc_misaligned, output_forward;
  logic [4:0]  forward_rd_addr;
  logic [31:0] forward_rd_val;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .in_valid(in_valid),
    .forward(forward), .rd_addr(rd_addr), .rd_val(rd_val), .ins_type(ins_type),
    .ins_details(ins_details), .mem_addr(mem_addr), .mem_val(mem_val),
    .memctl_op(memctl_op), .memctl_len(memctl_len), .memctl_addr(memctl_addr),
    .memctl_data(memctl_data), .memctl_fin(memctl_fin), .memctl_out(memctl_out),
    .stall(stall), .out_valid(out_valid), .output_rd_addr(output_rd_addr),
    .output_rd_val(output_rd_val), .output_ins_type(output_ins_type),
    .exc_misaligned(exc_misaligned), .output_forward(output_forward),
    .forward_rd_addr(forward_rd_addr), .forward_rd_val(forward_rd_val)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; forward = 1'b0; rd_addr = '0; rd_val = '0;
    ins_type = OP_ADDI; ins_details = '0; mem_addr = '0; mem_val = '0;
  endtask

  task automatic drive(input logic [6:0] t, input logic [2:0] f3, input logic [4:0] rd,
                       input logic fwd, input logic [31:0] rv, input logic [31:0] addr,
                       input logic [31:0] data);
    in_valid = 1'b1; ins_type = t; ins_details = f3; rd_addr = rd; forward = fwd;
    rd_val = rv; mem_addr = addr; mem_val = data;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input int waits, input logic [31:0] raw,
                          input logic [31:0] exp, input logic [1:0] exp_len);
    drive(OP_LOAD, f3, rd, 1'b0, 32'h0, addr, 32'h0);
    tick();
    idle_in();
    #1;
    check({tag, " len"}, memctl_len, exp_len);
    for (int i = 0; i < waits; i++) begin
      check({tag, " stall"}, stall, STALL_MEM);
      check({tag, " op"}, memctl_op, MEM_LOAD);
      check({tag, " addr"}, memctl_addr, addr);
      tick();
    end
    memctl_fin = 1'b1;
    memctl_out = raw;
    #1;
    check({tag, " fin stall"}, stall, 3'b000);
    check({tag, " early fwd"}, output_forward, 1'b1);
    check({tag, " early fwd val"}, forward_rd_val, exp);
    tick();
    memctl_fin = 1'b0;
    memctl_out = 32'h0;
    #1;
    check({tag, " out_valid"}, out_valid, 1'b1);
    check({tag, " rd"}, output_rd_addr, rd);
    check({tag, " val"}, output_rd_val, exp);
    check({tag, " op nop"}, memctl_op, MEM_NOP);
    tick();
    check({tag, " out_valid drop"}, out_valid, 1'b0);
  endtask

  task automatic run_mis(input string tag, input logic [6:0] t, input logic [2:0] f3,
                         input logic [31:0] addr);
    drive(t, f3, 5'd5, 1'b1, 32'h0, addr, 32'h1234);
    tick();
    idle_in();
    #1;
    check({tag, " op"}, memctl_op, MEM_NOP);
    check({tag, " out_valid"}, out_valid, 1'b1);
    check({tag, " exc"}, exc_misaligned, 1'b1);
    check({tag, " rd"}, output_rd_addr, 5'd0);
    check({tag, " fwd"}, output_forward, 1'b0);
    check({tag, " stall"}, stall, 3'b000);
    check({tag, " type"}, output_ins_type, t);
    tick();
    check({tag, " exc drop"}, exc_misaligned, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; memctl_fin = 1'b0; memctl_out = '0;
    idle_in();
    tick(); tick();
    check("rst op", memctl_op, MEM_NOP);
    check("rst addr", memctl_addr, 32'h0);
    check("rst out_valid", out_valid, 1'b0);
    check("rst ins_type", output_ins_type, OP_ADDI);
    check("rst stall", stall, 3'b000);
    check("rst fwd", output_forward, 1'b0);
    rst_in = 1'b1;
    tick();

    run_load("LB",  F3_LB,  32'h100, 5'd3, 3, 32'h80,   32'hFFFF_FF80, MEM_BYTE);
    run_load("LBU", F3_LBU, 32'h101, 5'd3, 1, 32'h80,   32'h0000_0080, MEM_BYTE);
    run_load("LH",  F3_LH,  32'h102, 5'd4, 2, 32'h8001, 32'hFFFF_8001, MEM_HALF);
    run_load("LHU", F3_LHU, 32'h106, 5'd4, 2, 32'h8001, 32'h0000_8001, MEM_HALF);
    run_load("LW",  F3_LW,  32'h108, 5'd2, 0, 32'h1234_5678, 32'h1234_5678, MEM_WORD);

    // store then load back-to-back
    drive(OP_SAVE, F3_SW, 5'd9, 1'b0, 32'h0, 32'h104, 32'hDEAD_BEEF);
    tick();
    idle_in();
    #1;
    check("SW op", memctl_op, MEM_SAVE);
    check("SW len", memctl_len, MEM_WORD);
    check("SW data", memctl_data, 32'hDEAD_BEEF);
    check("SW stall", stall, STALL_MEM);
    memctl_fin = 1'b1;
    drive(OP_LOAD, F3_LW, 5'd6, 1'b0, 32'h0, 32'h104, 32'h0);
    #1;
    check("SW fin stall", stall, 3'b000);
    tick();
    idle_in();
    memctl_fin = 1'b0;
    #1;
    check("b2b op", memctl_op, MEM_LOAD);
    check("b2b addr", memctl_addr, 32'h104);
    check("b2b stall", stall, STALL_MEM);
    check("SW out_valid", out_valid, 1'b1);
    check("SW rd", output_rd_addr, 5'd0);
    check("SW type", output_ins_type, OP_SAVE);
    check("SW fwd", output_forward, 1'b0);
    memctl_fin = 1'b1;
    memctl_out = 32'hDEAD_BEEF;
    tick();
    memctl_fin = 1'b0;
    memctl_out = '0;
    #1;
    check("b2b LW rd", output_rd_addr, 5'd6);
    check("b2b LW val", output_rd_val, 32'hDEAD_BEEF);
    check("b2b LW op nop", memctl_op, MEM_NOP);
    tick();

    run_mis("LW mis", OP_LOAD, F3_LW, 32'h102);
    run_mis("SH mis", OP_SAVE, F3_SH, 32'h101);
    run_mis("bad f3", OP_LOAD, 3'd3, 32'h100);

    // ALU ops and forwarding
    drive(OP_ADDI, 3'd0, 5'd5, 1'b1, 32'd7, 32'h0, 32'h0);
    tick();
    idle_in();
    #1;
    check("ADDI out_valid", out_valid, 1'b1);
    check("ADDI fwd", output_forward, 1'b1);
    check("ADDI fwd rd", forward_rd_addr, 5'd5);
    check("ADDI fwd val", forward_rd_val, 32'd7);
    drive(OP_ADDI, 3'd0, 5'd5, 1'b0, 32'd7, 32'h0, 32'h0);
    tick();
    idle_in();
    #1;
    check("ADDI nofwd rd", output_rd_addr, 5'd0);
    check("ADDI nofwd fwd", output_forward, 1'b0);
    drive(OP_ADDI, 3'd0, 5'd0, 1'b1, 32'd9, 32'h0, 32'h0);
    tick();
    idle_in();
    #1;
    check("ADDI rd0 fwd", output_forward, 1'b0);
    tick();

    // ALU op accepted in the load's completion cycle retires one cycle later
    drive(OP_LOAD, F3_LW, 5'd2, 1'b0, 32'h0, 32'h110, 32'h0);
    tick();
    idle_in();
    memctl_fin = 1'b1;
    memctl_out = 32'hCAFE_0001;
    drive(OP_ADDI, 3'd0, 5'd4, 1'b1, 32'h44, 32'h0, 32'h0);
    tick();
    idle_in();
    memctl_fin = 1'b0;
    memctl_out = '0;
    #1;
    check("hold LW rd", output_rd_addr, 5'd2);
    check("hold LW val", output_rd_val, 32'hCAFE_0001);
    check("hold stall", stall, 3'b000);
    tick();
    check("hold ADDI valid", out_valid, 1'b1);
    check("hold ADDI rd", output_rd_addr, 5'd4);
    check("hold ADDI fwd val", forward_rd_val, 32'h44);
    tick();
    check("hold drop", out_valid, 1'b0);

    // rdy_in freeze
    drive(OP_ADDI, 3'd0, 5'd7, 1'b1, 32'h55, 32'h0, 32'h0);
    tick();
    idle_in();
    rdy_in = 1'b0;
    tick();
    check("frz out_valid", out_valid, 1'b1);
    tick();
    check("frz out_valid 2", out_valid, 1'b1);
    check("frz val", output_rd_val, 32'h55);
    rdy_in = 1'b1;
    tick();
    check("frz release", out_valid, 1'b0);
    drive(OP_LOAD, F3_LW, 5'd8, 1'b0, 32'h0, 32'h200, 32'h0);
    tick();
    idle_in();
    rdy_in = 1'b0;
    memctl_fin = 1'b1;
    memctl_out = 32'h99;
    #1;
    check("frz fin stall", stall, 3'b000);
    check("frz no early fwd", output_forward, 1'b0);
    tick(); tick();
    memctl_fin = 1'b0;
    #1;
    check("frz busy stall", stall, STALL_MEM);
    check("frz busy op", memctl_op, MEM_LOAD);
    check("frz busy out_valid", out_valid, 1'b0);
    rdy_in = 1'b1;
    memctl_fin = 1'b1;
    tick();
    memctl_fin = 1'b0;
    #1;
    check("frz done rd", output_rd_addr, 5'd8);
    check("frz done val", output_rd_val, 32'h99);
    tick();

    // reset during BUSY, then stray fin in IDLE
    drive(OP_LOAD, F3_LW, 5'd9, 1'b0, 32'h0, 32'h300, 32'h0);
    tick();
    idle_in();
    check("rstb op", memctl_op, MEM_LOAD);
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    check("rstb op nop", memctl_op, MEM_NOP);
    check("rstb addr", memctl_addr, 32'h0);
    check("rstb stall", stall, 3'b000);
    check("rstb ins_type", output_ins_type, OP_ADDI);
    memctl_fin = 1'b1;
    tick();
    memctl_fin = 1'b0;
    #1;
    check("idle fin out_valid", out_valid, 1'b0);
    check("idle fin op", memctl_op, MEM_NOP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
